edusoc_lsu: RTL and testbench
=============================

EDUSOC_LSU -- requirements
Module: edusoc_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-wait limit in cycles (used only with EDUSOC_LSU_TIMEOUT_EN).
REQ-002 SHALL have clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have resn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have core-side inputs: lsu_req 1 (access request); lsu_we 1 (store); lsu_size 2 (00 byte, 01 half, 10 word, 11 illegal); lsu_unsigned 1 (zero-extend loads); lsu_addr 32; lsu_wdata 32 (store data, LSB-aligned).
REQ-005 SHALL have core-side outputs: lsu_ready 1 (can accept); lsu_done 1 (one-cycle completion pulse); lsu_rdata 32 (extended load data); lsu_misaligned 1; lsu_bus_err 1.
REQ-006 SHALL have data-bus outputs data_req 1, data_we 1, data_be 4, data_addr 32 (word-aligned), data_wdata 32, and inputs data_valid 1, data_rdata 32.

Function
REQ-007 SHALL implement states IDLE, BUSY, RESP; lsu_ready = (state==IDLE).
REQ-008 SHALL accept a request when lsu_req && lsu_ready, registering all lsu_* inputs in that cycle (N).
REQ-009 SHALL flag misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0; size 11): go IDLE->RESP, issue no bus transaction, pulse lsu_done with lsu_misaligned=1 at N+1.
REQ-010 SHALL for aligned accesses go IDLE->BUSY and drive data_req=1 from N+1 until the cycle data_valid is sampled high, holding data_addr={addr[31:2],2'b00}, data_we, data_be and data_wdata constant throughout.
REQ-011 SHALL generate data_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. It SHALL replicate store data across lanes (byte x4, half x2).
REQ-012 SHALL accept data_valid in the first cycle data_req is high (zero-wait slave), and in any later BUSY cycle.
REQ-013 SHALL on data_valid in BUSY go to RESP, deassert data_req the next cycle, and register the load result (lane selected by addr[1:0], sign- or zero-extended per lsu_unsigned). Stores SHALL return lsu_rdata=0.
REQ-014 SHALL in RESP pulse lsu_done for exactly one cycle, then return to IDLE. lsu_rdata, lsu_misaligned and lsu_bus_err SHALL be valid only while lsu_done=1 and SHALL be 0 otherwise.
REQ-015 SHALL ignore data_valid while IDLE or RESP.
REQ-016 Minimum aligned latency SHALL be: accept N, data_req N+1, data_valid N+1, lsu_done N+2; a new request SHALL be accepted at N+3 at the earliest.

Reset
REQ-017 SHALL while resn=0 force state IDLE, data_req/data_we/lsu_done/lsu_misaligned/lsu_bus_err=0, data_be=0, data_addr/data_wdata/lsu_rdata=0, lsu_ready=1.
REQ-018 SHALL abandon any in-flight transaction on reset: data_req drops asynchronously, and a stale data_valid after release is ignored per REQ-015.

Configuration
REQ-019 With EDUSOC_LSU_TIMEOUT_EN defined, a counter SHALL start at 0 on entering BUSY. If data_valid has not arrived after TIMEOUT_CYCLES BUSY cycles, the block SHALL drop data_req, enter RESP, and pulse lsu_done with lsu_bus_err=1 and lsu_rdata=0. data_valid in the expiry cycle SHALL take priority (normal completion).
REQ-020 Without EDUSOC_LSU_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely, and lsu_bus_err SHALL be tied 0.

Structure
REQ-021 Package edusoc_lsu_pkg SHALL hold the lsu_size_t enum (BYTE, HALF, WORD) and the lsu_state_t enum (IDLE, BUSY, RESP).
REQ-022 Combinational lane steering (data_be, store replication, load extract/extend) SHALL reside in sub-module edusoc_lsu_align; edusoc_lsu holds the FSM and registers.

Verification
REQ-023 Word store of 0xDEADBEEF to 0x1000_0004 with a zero-wait slave -> data_addr=0x1000_0004, be=1111, wdata=0xDEADBEEF, data_req high one cycle, lsu_done at N+2.
REQ-024 Byte load from 0x0000_0103 returning rdata=0x80xxxxxx -> be=1000; signed gives lsu_rdata=0xFFFFFF80; unsigned gives 0x00000080.
REQ-025 Half store of 0x1234 to 0x0000_0202 with the slave waiting 5 cycles -> be=1100, wdata=0x12341234, req/addr stable all 5 cycles, one lsu_done.
REQ-026 Half load from 0x0000_0001 -> no data_req, lsu_done with lsu_misaligned=1 at N+1, lsu_ready again at N+2.
REQ-027 EDUSOC_LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and a silent slave -> data_req drops after 4 cycles, lsu_done with lsu_bus_err=1; repeat with valid in the 4th cycle -> normal done, bus_err=0.
REQ-028 resn pulsed low mid-BUSY, then data_valid one cycle after release -> data_req=0 immediately, no lsu_done, lsu_ready=1.

Source files
------------

// File: rtl/edusoc_lsu_pkg.sv
// rtl/edusoc_lsu_pkg.sv - shared types and the alignment rule for the edusoc load/store unit
package edusoc_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } lsu_state_t;

    // Size code 2'b11 has no enum member and is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            BYTE:    is_misaligned = 1'b0;
            HALF:    is_misaligned = offset[0];
            WORD:    is_misaligned = (offset != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/edusoc_lsu_align.sv
// rtl/edusoc_lsu_align.sv - combinational lane steering: byte enables, store replication, load extract/extend
module edusoc_lsu_align
    import edusoc_lsu_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_size)
            BYTE: begin
                st_be        = 4'b0001 << st_offset;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            HALF: begin
                st_be        = 4'b0011 << st_offset;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            WORD: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    assign lane = ld_rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = lane;
        case (ld_size)
            BYTE:    ld_data = {{24{~ld_unsigned & lane[7]}}, lane[7:0]};
            HALF:    ld_data = {{16{~ld_unsigned & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

endmodule

// File: rtl/edusoc_lsu.sv
// rtl/edusoc_lsu.sv - load/store unit FSM and registers; EDUSOC_LSU_TIMEOUT_EN adds a bus-wait timeout
module edusoc_lsu
    import edusoc_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misaligned,
    output logic        lsu_bus_err,
    output logic        data_req,
    output logic        data_we,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_valid,
    input  logic [31:0] data_rdata
);

    lsu_state_t  state;
    logic        we_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;

    edusoc_lsu_align u_align (
        .st_offset    (lsu_addr[1:0]),
        .st_size      (lsu_size),
        .st_wdata     (lsu_wdata),
        .st_be        (be_c),
        .st_wdata_rep (wdata_c),
        .ld_offset    (offset_q),
        .ld_size      (size_q),
        .ld_unsigned  (unsigned_q),
        .ld_rdata     (data_rdata),
        .ld_data      (load_c)
    );

    assign lsu_ready = (state == IDLE);

`ifdef EDUSOC_LSU_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;
    assign lsu_bus_err = bus_err_q;
`else
    // The limit only matters when the timeout is built in; the error output is constant 0.
    localparam logic TIMEOUT_SET = (TIMEOUT_CYCLES != 0);
    assign lsu_bus_err = 1'b0 & TIMEOUT_SET;
`endif

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            unsigned_q     <= 1'b0;
            size_q         <= 2'b00;
            offset_q       <= 2'b00;
            lsu_done       <= 1'b0;
            lsu_rdata      <= 32'h0;
            lsu_misaligned <= 1'b0;
            data_req       <= 1'b0;
            data_we        <= 1'b0;
            data_be        <= 4'b0000;
            data_addr      <= 32'h0;
            data_wdata     <= 32'h0;
`ifdef EDUSOC_LSU_TIMEOUT_EN
            wait_cnt       <= '0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req) begin
                        we_q       <= lsu_we;
                        unsigned_q <= lsu_unsigned;
                        size_q     <= lsu_size;
                        offset_q   <= lsu_addr[1:0];
                        if (is_misaligned(lsu_size, lsu_addr[1:0])) begin
                            state          <= RESP;
                            lsu_done       <= 1'b1;
                            lsu_misaligned <= 1'b1;
                        end else begin
                            state      <= BUSY;
                            data_req   <= 1'b1;
                            data_we    <= lsu_we;
                            data_be    <= be_c;
                            data_addr  <= {lsu_addr[31:2], 2'b00};
                            data_wdata <= wdata_c;
`ifdef EDUSOC_LSU_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (data_valid) begin
                        state     <= RESP;
                        data_req  <= 1'b0;
                        lsu_done  <= 1'b1;
                        lsu_rdata <= we_q ? 32'h0 : load_c;
`ifdef EDUSOC_LSU_TIMEOUT_EN
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= RESP;
                        data_req  <= 1'b0;
                        lsu_done  <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    lsu_done       <= 1'b0;
                    lsu_rdata      <= 32'h0;
                    lsu_misaligned <= 1'b0;
`ifdef EDUSOC_LSU_TIMEOUT_EN
                    bus_err_q      <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edusoc_lsu.sv
// tb/tb_edusoc_lsu.sv - self-checking bench for edusoc_lsu with a behavioural access model
module tb_edusoc_lsu;

    logic        clk = 1'b0;
    logic        resn = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic        lsu_unsigned = 1'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_ready, lsu_done, lsu_misaligned, lsu_bus_err;
    logic [31:0] lsu_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_valid = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

`ifdef EDUSOC_LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    edusoc_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resn(resn),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_misaligned(lsu_misaligned), .lsu_bus_err(lsu_bus_err),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_valid(data_valid), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    // Observations of the most recent transaction, relative to accept cycle N.
    int          o_done_at, o_req_cycles, o_done_cnt;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_we, o_stable, o_mis, o_berr, o_ready_done, o_ready_after, o_bad_idle, o_ready_acc;

    // Access model: alignment, byte enables, store replication and load extension from plain arithmetic.
    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (off % 2) != 0;
        if (size == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w % 256) * 32'h01010101;
        if (size == 2'd1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] bus);
        int unsigned lane = bus / (1 << (8 * (addr % 4)));
        int unsigned bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        longint v;
        if (bits == 32) return lane;
        v = lane % (1 << bits);
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // lat: cycle of data_req (1-based) in which the slave answers; 0 = silent slave.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input logic [31:0] srd, input bit noise);
        o_done_at = -1; o_req_cycles = 0; o_done_cnt = 0; o_stable = 1'b1;
        o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0; o_rdata = 32'h0;
        o_mis = 1'b0; o_berr = 1'b0; o_ready_done = 1'b1; o_ready_after = 1'b0; o_bad_idle = 1'b0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        o_ready_acc = lsu_ready;
        @(posedge clk);
        #1;
        lsu_req = 1'b0; lsu_wdata = $urandom; lsu_addr = $urandom;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            data_valid = 1'b0;
            data_rdata = $urandom;
            if (data_req) begin
                o_req_cycles++;
                if (o_req_cycles == 1) begin
                    o_be = data_be; o_addr = data_addr; o_wdata = data_wdata; o_we = data_we;
                end else if (data_be !== o_be || data_addr !== o_addr || data_wdata !== o_wdata || data_we !== o_we) begin
                    o_stable = 1'b0;
                end
                if (o_req_cycles == lat) begin
                    data_valid = 1'b1;
                    data_rdata = srd;
                end
            end else if (noise) begin
                data_valid = 1'($urandom);
            end
            if (lsu_done) begin
                o_done_cnt++;
                o_done_at = k; o_rdata = lsu_rdata; o_mis = lsu_misaligned; o_berr = lsu_bus_err;
                o_ready_done = lsu_ready;
            end else if (lsu_rdata !== 32'h0 || lsu_misaligned !== 1'b0 || lsu_bus_err !== 1'b0) begin
                o_bad_idle = 1'b1;
            end
            if (o_done_at > 0 && k == o_done_at + 1) o_ready_after = lsu_ready;
            if (o_done_at > 0 && k == o_done_at + 2) break;
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        resn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({data_req, data_we, lsu_done, lsu_misaligned, lsu_bus_err, lsu_ready} !== 6'b000001) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000001", {data_req, data_we, lsu_done, lsu_misaligned, lsu_bus_err, lsu_ready}); end
        checks++; if (data_be !== 4'h0) begin failures++; $display("FAIL reset_be got=%h exp=0", data_be); end
        checks++; if ({data_addr, data_wdata, lsu_rdata} !== 96'h0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", data_addr, data_wdata, lsu_rdata); end
        resn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        run_txn(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 1, 32'h5555_AAAA, 1'b0);
        checks++; if (o_addr !== 32'h1000_0004) begin failures++; $display("FAIL ws_addr got=%h exp=10000004", o_addr); end
        checks++; if ({o_be, o_we} !== 5'b11111) begin failures++; $display("FAIL ws_be_we got=%b exp=11111", {o_be, o_we}); end
        checks++; if (o_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ws_wdata got=%h exp=deadbeef", o_wdata); end
        checks++; if (o_req_cycles !== 1 || o_done_at !== 2) begin
            failures++; $display("FAIL ws_timing req=%0d done=%0d exp=1/2", o_req_cycles, o_done_at); end
        checks++; if (o_rdata !== 32'h0 || o_ready_after !== 1'b1) begin
            failures++; $display("FAIL ws_rdata_ready got=%h/%b exp=0/1", o_rdata, o_ready_after); end
    endtask

    task automatic test_byte_load();
        logic [31:0] srd;
        srd = 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 1, srd, 1'b0);
        checks++; if (o_be !== 4'b1000) begin failures++; $display("FAIL bl_be got=%b exp=1000", o_be); end
        checks++; if (o_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL bl_signed got=%h exp=ffffff80", o_rdata); end
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 1, srd, 1'b0);
        checks++; if (o_rdata !== 32'h0000_0080) begin failures++; $display("FAIL bl_unsigned got=%h exp=00000080", o_rdata); end
    endtask

    task automatic test_half_store_wait();
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hABCD_1234, 5, 32'h0, 1'b0);
        checks++; if (o_be !== 4'b1100 || o_wdata !== 32'h1234_1234) begin
            failures++; $display("FAIL hs_lanes got=%b/%h exp=1100/12341234", o_be, o_wdata); end
        checks++; if (o_req_cycles !== 5 || o_stable !== 1'b1 || o_addr !== 32'h0000_0200) begin
            failures++; $display("FAIL hs_hold req=%0d stable=%b addr=%h exp=5/1/00000200", o_req_cycles, o_stable, o_addr); end
        checks++; if (o_done_cnt !== 1 || o_done_at !== 6) begin
            failures++; $display("FAIL hs_done cnt=%0d at=%0d exp=1/6", o_done_cnt, o_done_at); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 1, 32'h0, 1'b0);
        checks++; if (o_req_cycles !== 0 || o_done_at !== 1 || o_mis !== 1'b1) begin
            failures++; $display("FAIL mis_half req=%0d done=%0d mis=%b exp=0/1/1", o_req_cycles, o_done_at, o_mis); end
        checks++; if (o_ready_done !== 1'b0 || o_ready_after !== 1'b1) begin
            failures++; $display("FAIL mis_ready got=%b/%b exp=0/1", o_ready_done, o_ready_after); end
        run_txn(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b0);
        checks++; if (o_req_cycles !== 0 || o_mis !== 1'b1 || o_done_at !== 1) begin
            failures++; $display("FAIL mis_size3 req=%0d mis=%b done=%0d exp=0/1/1", o_req_cycles, o_mis, o_done_at); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        we, uns, mis;
            logic [1:0]  size;
            logic [31:0] addr, wdata, srd, exp_rd;
            int          lat;
            we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom_range(0, 3));
            addr = $urandom; wdata = $urandom; srd = $urandom; lat = $urandom_range(1, 4);
            if ($urandom_range(0, 3) != 0) addr[1:0] = (size == 2'd2) ? 2'b00 : (size == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
            mis = m_mis(size, addr);
            exp_rd = (mis || we) ? 32'h0 : m_load(size, uns, addr, srd);
            run_txn(we, size, uns, addr, wdata, lat, srd, 1'b1);
            checks++; if (o_mis !== mis || o_done_cnt !== 1 || o_done_at !== (mis ? 1 : lat + 1) || o_req_cycles !== (mis ? 0 : lat)) begin
                failures++; $display("FAIL rnd%0d_flow mis=%b cnt=%0d at=%0d req=%0d exp=%b/1/%0d/%0d", t, o_mis, o_done_cnt, o_done_at, o_req_cycles, mis, mis ? 1 : lat + 1, mis ? 0 : lat); end
            checks++; if (o_rdata !== exp_rd) begin
                failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, o_rdata, exp_rd); end
            if (!mis) begin
                checks++; if (o_be !== m_be(size, addr) || o_addr !== (addr & 32'hFFFF_FFFC) || o_we !== we || o_stable !== 1'b1) begin
                    failures++; $display("FAIL rnd%0d_bus be=%h addr=%h we=%b stable=%b exp=%h/%h/%b/1", t, o_be, o_addr, o_we, o_stable, m_be(size, addr), addr & 32'hFFFF_FFFC, we); end
                if (we) begin
                    checks++; if (o_wdata !== m_wdata(size, wdata)) begin
                        failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", t, o_wdata, m_wdata(size, wdata)); end
                end
            end
            checks++; if (o_bad_idle !== 1'b0 || o_ready_acc !== 1'b1 || o_ready_after !== 1'b1 || o_berr !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_side bad=%b acc=%b after=%b berr=%b exp=0/1/1/0", t, o_bad_idle, o_ready_acc, o_ready_after, o_berr); end
        end
    endtask

`ifdef EDUSOC_LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0);
        checks++; if (o_req_cycles !== 4 || o_done_at !== 5 || o_berr !== 1'b1 || o_rdata !== 32'h0) begin
            failures++; $display("FAIL tmo_silent req=%0d at=%0d berr=%b rd=%h exp=4/5/1/0", o_req_cycles, o_done_at, o_berr, o_rdata); end
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 4, 32'h1357_9BDF, 1'b0);
        checks++; if (o_req_cycles !== 4 || o_berr !== 1'b0 || o_rdata !== 32'h1357_9BDF) begin
            failures++; $display("FAIL tmo_last req=%0d berr=%b rd=%h exp=4/0/13579bdf", o_req_cycles, o_berr, o_rdata); end
    endtask
`endif

    task automatic test_reset_mid_busy();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h0000_0080;
        @(posedge clk);
        #1 lsu_req = 1'b0;
        @(negedge clk);
        checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL rst_busy_req got=%b exp=1", data_req); end
        @(posedge clk);
        #2 resn = 1'b0;
        #1;
        checks++; if (data_req !== 1'b0 || lsu_ready !== 1'b1) begin
            failures++; $display("FAIL rst_async req=%b ready=%b exp=0/1", data_req, lsu_ready); end
        @(negedge clk);
        resn = 1'b1;
        @(negedge clk);
        data_valid = 1'b1; data_rdata = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            data_valid = 1'b0;
            if (lsu_done !== 1'b0 || data_req !== 1'b0 || lsu_ready !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rst_stale_valid got=%b exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store_wait();
        test_misaligned();
        test_random();
`ifdef EDUSOC_LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
